// File: rtl/fwd_merge_pkg.sv
// Shared constants for the forwarder-side merge: split-stage choice encoding and default widths.
package fwd_merge_pkg;

  localparam logic CHOICE_LEFT  = 1'b0;
  localparam logic CHOICE_RIGHT = 1'b1;

  localparam int DATA_WIDTH_DEF      = 64;
  localparam int ADDR_WIDTH_DEF      = 10;
  localparam int LEN_WIDTH_DEF       = 12;
  localparam int ORDER_DEPTH_LOG_DEF = 3;

endpackage

// File: rtl/fwd_merge_order_fifo.sv
// 1-bit order FIFO holding one split-stage choice per outstanding packet.
module order_fifo #(
  parameter int DEPTH_LOG = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               push,
  input  logic               din,
  input  logic               pop,
  output logic               dout,
  output logic               full,
  output logic               empty,
  output logic               overflow,
  output logic [DEPTH_LOG:0] count
);

  localparam int DEPTH = 1 << DEPTH_LOG;
  localparam logic [DEPTH_LOG:0] FULL_CNT = (DEPTH_LOG + 1)'(DEPTH);

  logic [DEPTH-1:0]     mem;
  logic [DEPTH_LOG-1:0] wr_ptr;
  logic [DEPTH_LOG-1:0] rd_ptr;
  logic                 do_push;
  logic                 do_pop;

  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);
  assign dout  = mem[rd_ptr];

  // A pop frees the slot in the same cycle, so push+pop is accepted even when full.
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign overflow = push && full && !do_pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fwd_merge.sv
// Merges the left/right branches of one split stage back into arrival order for the forwarder.
// Handshake: ready=1 offers the head packet; done (only honoured while ready=1) retires it.
module fwd_merge
  import fwd_merge_pkg::*;
#(
  parameter int DATA_WIDTH      = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH      = ADDR_WIDTH_DEF,
  parameter int LEN_WIDTH       = LEN_WIDTH_DEF,
  parameter int ORDER_DEPTH_LOG = ORDER_DEPTH_LOG_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     choice,
  input  logic                     choice_valid,
  output logic                     order_full,
  output logic                     overflow_err,
  input  logic [ADDR_WIDTH-1:0]    rd_addr,
  input  logic                     rd_en,
  output logic [DATA_WIDTH-1:0]    rd_data,
  output logic                     ready,
  output logic [LEN_WIDTH-1:0]     len,
  input  logic                     done,
  output logic [ADDR_WIDTH-1:0]    rd_addr_l,
  output logic [ADDR_WIDTH-1:0]    rd_addr_r,
  output logic                     rd_en_l,
  output logic                     rd_en_r,
  input  logic [DATA_WIDTH-1:0]    rd_data_l,
  input  logic [DATA_WIDTH-1:0]    rd_data_r,
  input  logic                     ready_l,
  input  logic                     ready_r,
  input  logic [LEN_WIDTH-1:0]     len_l,
  input  logic [LEN_WIDTH-1:0]     len_r,
  output logic                     done_l,
  output logic                     done_r,
  input  logic                     rej_l,
  input  logic                     rej_r,
  output logic [1:0]               dbg_state,
  output logic [ORDER_DEPTH_LOG:0] dbg_count,
  output logic [ORDER_DEPTH_LOG:0] dbg_rej_l,
  output logic [ORDER_DEPTH_LOG:0] dbg_rej_r
);

  localparam int CW = ORDER_DEPTH_LOG + 1;
  localparam logic [CW-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_FWD  = 2'd2
  } state_t;

  state_t        state_q;
  state_t        state_d;
  logic          sel;
  logic          sel_q;
  logic          rd_vld_q;
  logic          pop;
  logic          take_l;
  logic          take_r;
  logic [CW-1:0] rej_cnt_l;
  logic [CW-1:0] rej_cnt_r;
  logic          fifo_full;
  logic          fifo_empty;
  logic          ovf_pulse;
  logic [CW-1:0] fifo_count;
  logic          in_fwd;
  logic          rej_pend_sel;
  logic          ready_sel;
  logic          entries_remain;

  order_fifo #(.DEPTH_LOG(ORDER_DEPTH_LOG)) u_order_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (choice_valid),
    .din      (choice),
    .pop      (pop),
    .dout     (sel),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .overflow (ovf_pulse),
    .count    (fifo_count)
  );

  function automatic logic [CW-1:0] rej_next(input logic [CW-1:0] c, input logic inc,
                                             input logic dec);
    rej_next = c;
    if (inc && !dec && c != CNT_MAX) rej_next = c + 1'b1;
    else if (dec && !inc)            rej_next = c - 1'b1;
  endfunction

  assign in_fwd       = (state_q == ST_FWD);
  assign rej_pend_sel = (sel == CHOICE_RIGHT) ? (rej_cnt_r != '0) : (rej_cnt_l != '0);
  assign ready_sel    = (sel == CHOICE_RIGHT) ? ready_r : ready_l;
  // Any pop here is of a non-empty FIFO, so a same-cycle push is always accepted.
  assign entries_remain = (fifo_count > CW'(1)) || choice_valid;

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    take_l  = 1'b0;
    take_r  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // A pending reject on the head's branch retires it even if that branch is ready.
        if (rej_pend_sel) begin
          pop     = 1'b1;
          take_l  = (sel == CHOICE_LEFT);
          take_r  = (sel == CHOICE_RIGHT);
          state_d = entries_remain ? ST_WAIT : ST_IDLE;
        end else if (ready_sel) begin
          state_d = ST_FWD;
        end
      end
      ST_FWD: begin
        if (done) begin
          pop     = 1'b1;
          state_d = entries_remain ? ST_WAIT : ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      sel_q        <= 1'b0;
      rd_vld_q     <= 1'b0;
      rej_cnt_l    <= '0;
      rej_cnt_r    <= '0;
      overflow_err <= 1'b0;
    end else begin
      state_q      <= state_d;
      sel_q        <= sel;
      rd_vld_q     <= in_fwd && rd_en;
      rej_cnt_l    <= rej_next(rej_cnt_l, rej_l, take_l);
      rej_cnt_r    <= rej_next(rej_cnt_r, rej_r, take_r);
      overflow_err <= overflow_err | ovf_pulse;
    end
  end

  assign ready     = in_fwd;
  assign len       = in_fwd ? ((sel == CHOICE_RIGHT) ? len_r : len_l) : '0;
  assign rd_en_l   = in_fwd && (sel == CHOICE_LEFT) && rd_en;
  assign rd_en_r   = in_fwd && (sel == CHOICE_RIGHT) && rd_en;
  assign done_l    = in_fwd && (sel == CHOICE_LEFT) && done;
  assign done_r    = in_fwd && (sel == CHOICE_RIGHT) && done;
  assign rd_addr_l = rd_addr;
  assign rd_addr_r = rd_addr;
  // Branch data returns one cycle after rd_en, so it is steered by the delayed select.
  assign rd_data   = rd_vld_q ? ((sel_q == CHOICE_RIGHT) ? rd_data_r : rd_data_l) : '0;

  assign order_full = fifo_full;
  assign dbg_state  = state_q;
  assign dbg_count  = fifo_count;
  assign dbg_rej_l  = rej_cnt_l;
  assign dbg_rej_r  = rej_cnt_r;

endmodule
